// File: rtl/requantize_stream_pkg.sv
// Shared defaults and width helpers for the streaming requantizer.
package requantize_stream_pkg;

    localparam int DEF_SIZE        = 4;
    localparam int DEF_IN_WIDTH    = 32;
    localparam int DEF_OUT_WIDTH   = 8;
    localparam int DEF_SHIFT_WIDTH = 6;

    // Wide enough to hold the largest left shift of an accumulator without loss.
    function automatic int wide_width(input int in_width, input int shift_width);
        return in_width + (1 << (shift_width - 1));
    endfunction

    function automatic int count_width(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/requantize_stream_if.sv
// Valid/ready stream bundle: accumulator beats in, requantized activation beats out.
interface requantize_stream_if
    import requantize_stream_pkg::*;
#(
    parameter int SIZE      = DEF_SIZE,
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
);
    logic                      in_valid;
    logic                      in_ready;
    logic [IN_WIDTH*SIZE-1:0]  pixel_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_WIDTH*SIZE-1:0] pixel_out;

    modport master (
        output in_valid, pixel_in, out_ready,
        input  in_ready, out_valid, pixel_out
    );

    modport slave (
        input  in_valid, pixel_in, out_ready,
        output in_ready, out_valid, pixel_out
    );
endinterface

// File: rtl/requantize_stream_lane.sv
// One requantizer lane: signed shift (optional round-half-up on right shifts when
// REQUANT_ROUND_EN is defined) feeding stage 1, and saturation of the stage-1 value.
module requantize_stream_lane
    import requantize_stream_pkg::*;
#(
    parameter int IN_WIDTH    = DEF_IN_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
    parameter int WIDE_W      = wide_width(IN_WIDTH, SHIFT_WIDTH)
) (
    input  logic signed [IN_WIDTH-1:0]    acc,
    input  logic signed [SHIFT_WIDTH-1:0] shift,
    output logic signed [WIDE_W-1:0]      wide,
    input  logic signed [WIDE_W-1:0]      wide_p1,
    output logic signed [OUT_WIDTH-1:0]   sat_out,
    output logic                          sat_flag
);
    localparam logic signed [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [WIDE_W-1:0]    MAX_W   = WIDE_W'(SAT_MAX);
    localparam logic signed [WIDE_W-1:0]    MIN_W   = WIDE_W'(SAT_MIN);
`ifdef REQUANT_ROUND_EN
    localparam logic signed [WIDE_W-1:0]    ONE_W   = WIDE_W'(1);
`endif

    function automatic logic signed [WIDE_W-1:0] shift_round(
        input logic signed [IN_WIDTH-1:0]    x,
        input logic signed [SHIFT_WIDTH-1:0] s
    );
        logic signed [WIDE_W-1:0] xw;
        logic [SHIFT_WIDTH:0]     amt;
        xw  = WIDE_W'(x);
        // One extra bit so that the most negative shift still yields a positive magnitude.
        amt = -{s[SHIFT_WIDTH-1], s};
        if (s > 0) begin
            return xw <<< s;
        end else if (s < 0) begin
`ifdef REQUANT_ROUND_EN
            xw = xw + (ONE_W <<< (amt - 1'b1));
`endif
            return xw >>> amt;
        end
        return xw;
    endfunction

    function automatic logic is_sat(input logic signed [WIDE_W-1:0] v);
        return (v > MAX_W) || (v < MIN_W);
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [WIDE_W-1:0] v);
        if (v > MAX_W) return SAT_MAX;
        if (v < MIN_W) return SAT_MIN;
        return v[OUT_WIDTH-1:0];
    endfunction

    assign wide     = shift_round(acc, shift);
    assign sat_out  = saturate(wide_p1);
    assign sat_flag = is_sat(wide_p1);

endmodule

// File: rtl/requantize_stream.sv
// Streaming multi-channel requantizer: per-lane runtime shift, saturation, valid/ready
// flow control and a sticky saturation counter. REQUANT_ROUND_EN enables round-half-up.
module requantize_stream
    import requantize_stream_pkg::*;
#(
    parameter int SIZE          = DEF_SIZE,
    parameter int IN_WIDTH      = DEF_IN_WIDTH,
    parameter int OUT_WIDTH     = DEF_OUT_WIDTH,
    parameter int SHIFT_WIDTH   = DEF_SHIFT_WIDTH,
    parameter int DEFAULT_SHIFT = 0,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    requantize_stream_if.slave          s,
    input  logic                        cfg_wr,
    input  logic [SHIFT_WIDTH*SIZE-1:0] cfg_shift,
    input  logic                        sat_clear,
    output logic [CNT_WIDTH-1:0]        sat_count
);
    localparam int WIDE_W = wide_width(IN_WIDTH, SHIFT_WIDTH);
    localparam int NSAT_W = count_width(SIZE);
    localparam int SUM_W  = CNT_WIDTH + NSAT_W;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                      adv;
    logic                      vld_p1;
    logic                      vld_p2;
    logic [SIZE-1:0]           sat_flag;
    logic [OUT_WIDTH*SIZE-1:0] pixel_nxt;
    logic [OUT_WIDTH*SIZE-1:0] pixel_p2;
    logic [NSAT_W-1:0]         nsat;
    logic [SUM_W-1:0]          sat_sum;
    logic [CNT_WIDTH-1:0]      sat_next;

    // The whole pipeline advances together whenever the output slot can move.
    assign adv         = ~vld_p2 | s.out_ready;
    assign s.in_ready  = adv;
    assign s.out_valid = vld_p2;
    assign s.pixel_out = pixel_p2;

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        logic signed [SHIFT_WIDTH-1:0] shift_q;
        logic signed [WIDE_W-1:0]      wide_p0;
        logic signed [WIDE_W-1:0]      wide_p1;
        logic signed [OUT_WIDTH-1:0]   sat_val;
        logic                          flag;

        // Shift is sampled at acceptance, so a cfg_wr in the same cycle affects only later beats.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                shift_q <= SHIFT_WIDTH'(DEFAULT_SHIFT);
            end else if (cfg_wr) begin
                shift_q <= $signed(cfg_shift[SHIFT_WIDTH*i +: SHIFT_WIDTH]);
            end
        end

        requantize_stream_lane #(
            .IN_WIDTH    (IN_WIDTH),
            .OUT_WIDTH   (OUT_WIDTH),
            .SHIFT_WIDTH (SHIFT_WIDTH),
            .WIDE_W      (WIDE_W)
        ) u_lane (
            .acc      ($signed(s.pixel_in[IN_WIDTH*i +: IN_WIDTH])),
            .shift    (shift_q),
            .wide     (wide_p0),
            .wide_p1  (wide_p1),
            .sat_out  (sat_val),
            .sat_flag (flag)
        );

        // Stage 0 -> 1: full-precision shifted value.
        always_ff @(posedge clock) begin
            if (adv && s.in_valid) begin
                wide_p1 <= wide_p0;
            end
        end

        assign pixel_nxt[OUT_WIDTH*i +: OUT_WIDTH] = sat_val;
        assign sat_flag[i] = flag;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (adv) begin
            vld_p1 <= s.in_valid;
            vld_p2 <= vld_p1;
        end
    end

    // Stage 1 -> 2: saturated output; bubbles leave the last value in place.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pixel_p2 <= '0;
        end else if (adv && vld_p1) begin
            pixel_p2 <= pixel_nxt;
        end
    end

    always_comb begin
        nsat = '0;
        for (int i = 0; i < SIZE; i++) begin
            nsat = nsat + NSAT_W'(sat_flag[i]);
        end
    end

    assign sat_sum  = SUM_W'(sat_count) + SUM_W'(nsat);
    assign sat_next = (sat_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sat_sum[CNT_WIDTH-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sat_count <= '0;
        end else if (sat_clear) begin
            sat_count <= '0;
        end else if (adv && vld_p1) begin
            sat_count <= sat_next;
        end
    end

endmodule

// File: tb/tb_requantize_stream.sv
// Scoreboard bench for requantize_stream: directed beats push expected outputs, a monitor pops and compares.
module tb_requantize_stream;

    logic        clock;
    logic        reset;
    logic        cfg_wr;
    logic [23:0] cfg_shift;
    logic        sat_clear;
    logic [3:0]  sat_count;

    requantize_stream_if #(.SIZE(4), .IN_WIDTH(32), .OUT_WIDTH(8)) bus ();

    requantize_stream #(
        .SIZE(4), .IN_WIDTH(32), .OUT_WIDTH(8), .SHIFT_WIDTH(6),
        .DEFAULT_SHIFT(0), .CNT_WIDTH(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .s         (bus),
        .cfg_wr    (cfg_wr),
        .cfg_shift (cfg_shift),
        .sat_clear (sat_clear),
        .sat_count (sat_count)
    );

    int          checks = 0;
    int          failures = 0;
    int          beats_out = 0;
    logic [31:0] exp_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] pk_in(input int a3, input int a2, input int a1, input int a0);
        return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    endfunction

    function automatic logic [23:0] pk_sh(input int s3, input int s2, input int s1, input int s0);
        return {6'(s3), 6'(s2), 6'(s1), 6'(s0)};
    endfunction

    // Monitor: compare every transferred beat; a stalled beat must hold its value.
    always @(negedge clock) begin
        if (reset && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%h required=none", bus.pixel_out);
            end else if (bus.out_ready) begin
                chk("beat", 64'(bus.pixel_out), 64'(exp_q.pop_front()));
                beats_out++;
            end else begin
                chk("stall_hold", 64'(bus.pixel_out), 64'(exp_q[0]));
            end
        end
    end

    task automatic send(input logic [127:0] d, input logic [31:0] e, input logic wr, input logic [23:0] sh);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.pixel_in = d;
        cfg_wr       = wr;
        cfg_shift    = sh;
        @(negedge clock);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        chk("accept", 64'(bus.in_ready), 64'd1);
        if (bus.in_ready) exp_q.push_back(e);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        cfg_wr       = 1'b0;
    endtask

    task automatic cfg(input logic [23:0] sh);
        cfg_shift = sh;
        cfg_wr    = 1'b1;
        @(posedge clock);
        #1;
        cfg_wr    = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(posedge clock);
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.pixel_in  = '0;
        bus.out_ready = 1'b1;
        cfg_wr        = 1'b0;
        cfg_shift     = '0;
        sat_clear     = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_pixel_out", 64'(bus.pixel_out), 64'd0);
        chk("rst_sat_count", 64'(sat_count), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Left shift by 3 with two saturating lanes; output appears on the second edge.
        cfg(pk_sh(3, 3, 3, 3));
        send(pk_in(0, -1, 3150, -5320), 32'h00f87f80, 1'b0, 24'd0);
        @(negedge clock);
        chk("latency_1", 64'(bus.out_valid), 64'd0);
        @(negedge clock);
        chk("latency_2", 64'(bus.out_valid), 64'd1);
        drain();
        chk("sat_count_t1", 64'(sat_count), 64'd2);

        // Arithmetic right shift by 3.
        cfg(pk_sh(-3, -3, -3, -3));
`ifdef REQUANT_ROUND_EN
        send(pk_in(127, -128, 16, -680), 32'h10f002ab, 1'b0, 24'd0);
`else
        send(pk_in(127, -128, 16, -680), 32'h0ff002ab, 1'b0, 24'd0);
`endif
        drain();
        chk("sat_count_t2", 64'(sat_count), 64'd2);

        // Eight back-to-back beats with a three-cycle downstream stall.
        cfg(pk_sh(0, 0, 0, 0));
        base = beats_out;
        fork
            begin
                for (int i = 1; i <= 8; i++) begin
                    send(pk_in(i, -i, 100 + i, -100 - i),
                         {8'(i), 8'(-i), 8'(100 + i), 8'(-100 - i)}, 1'b0, 24'd0);
                end
            end
            begin
                repeat (3) @(posedge clock);
                #1 bus.out_ready = 1'b0;
                @(negedge clock);
                chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                repeat (3) @(posedge clock);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", 64'(beats_out - base), 64'd8);

        // cfg_wr together with beat A: A keeps the old shifts, B sees the new ones.
        cfg(pk_sh(-3, -3, -3, -3));
        send(pk_in(16, 16, 16, 16), 32'h02020202, 1'b1, pk_sh(3, -3, 0, 1));
        send(pk_in(5, -40, -7, 9), 32'h28fbf912, 1'b0, 24'd0);
        drain();

        // Saturation counter: count, stick at all-ones, clear beats a simultaneous increment.
        cfg(pk_sh(3, 3, 3, 3));
        sat_clear = 1'b1;
        @(posedge clock);
        #1 sat_clear = 1'b0;
        chk("sat_clear_idle", 64'(sat_count), 64'd0);
        for (int i = 0; i < 3; i++) send(pk_in(1000, 1000, -1000, -1000), 32'h7f7f8080, 1'b0, 24'd0);
        drain();
        chk("sat_count_12", 64'(sat_count), 64'd12);
        for (int i = 0; i < 2; i++) send(pk_in(1000, 1000, -1000, -1000), 32'h7f7f8080, 1'b0, 24'd0);
        drain();
        chk("sat_count_stick", 64'(sat_count), 64'hf);
        send(pk_in(1000, 1000, -1000, -1000), 32'h7f7f8080, 1'b0, 24'd0);
        sat_clear = 1'b1;
        @(posedge clock);
        #1 sat_clear = 1'b0;
        drain();
        chk("sat_clear_wins", 64'(sat_count), 64'd0);

        // Reset with two beats in flight, then check defaults and a fresh beat.
        cfg(pk_sh(1, 1, 1, 1));
        bus.out_ready = 1'b0;
        send(pk_in(1000, 1000, -1000, -1000), 32'h7f7f8080, 1'b0, 24'd0);
        send(pk_in(5, 5, 5, 5), 32'h0a0a0a0a, 1'b0, 24'd0);
        chk("pre_rst_sat_count", 64'(sat_count), 64'd4);
        #2 reset = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_pixel_out", 64'(bus.pixel_out), 64'd0);
        chk("mid_rst_sat_count", 64'(sat_count), 64'd0);
        @(posedge clock);
        #1;
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("post_rst_no_out", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clock);
        #1;
        send(pk_in(5, -5, 100, -100), 32'h05fb649c, 1'b0, 24'd0);
        drain();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
